// File: rtl/fifo_cg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_cg_pkg
// Description : Shared constants and types for the fifo_cg byte FIFO.
//               c_data_width / c_addr_width are the default geometry
//               (8-bit words, 256 entries); data_t and ptr_t are the word
//               and pointer types at that default geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_cg_pkg;

  localparam int unsigned c_data_width = 8;
  localparam int unsigned c_addr_width = 8;

  typedef logic [c_data_width-1:0] data_t;
  typedef logic [c_addr_width-1:0] ptr_t;

endpackage : fifo_cg_pkg
`default_nettype wire

// File: rtl/fifo_cg_ram.sv
`default_nettype none
// ============================================================================
// Module      : fifo_cg_ram
// Description : DEPTH x DATA_WIDTH storage with one write port and one
//               registered read port (read register resets to 0).
//               Build option FIFO_CG_CLKGATE_EN: when defined, the array is
//               clocked by a latch-based gated clock enabled by i_we;
//               otherwise i_we is a plain write enable on clk.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               i_we, i_waddr,
//               i_wdata           - write enable / address / data
//               i_re, i_raddr     - read enable / address
//               o_rdata           - registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_cg_ram
  import fifo_cg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = c_data_width,
  parameter int unsigned ADDR_WIDTH = c_addr_width
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int unsigned c_depth = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [c_depth];
  logic [DATA_WIDTH-1:0] r_rdata;

`ifdef FIFO_CG_CLKGATE_EN
  // Enable is captured while clk is low so the gated clock can only pulse
  // for a full high phase of clk: no glitches from late enable changes.
  logic r_en_lat;
  logic w_gclk;

  always_latch begin
    if (!clk) r_en_lat <= i_we;
  end

  assign w_gclk = clk & r_en_lat;

  always_ff @(posedge w_gclk) begin
    r_mem[i_waddr] <= i_wdata;
  end
`else
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end
`endif

  // Read and write never target the same entry in one cycle: equal
  // pointers mean empty (no read) or full (no write).
  always_ff @(posedge clk) begin
    if (rst)       r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule : fifo_cg_ram
`default_nettype wire

// File: rtl/fifo_cg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_cg
// Description : Single-clock byte FIFO with registered read data, registered
//               Empty/Full flags and overflow/underflow protection.
//               Build option FIFO_CG_CLKGATE_EN clock-gates the storage
//               array (see fifo_cg_ram); port behaviour is unchanged.
// Ports       : CLK, RST - clock, synchronous active-high reset
//               Din      - write data
//               WR_EN    - write request (dropped while Full)
//               RD_EN    - read request (ignored while Empty)
//               Dout     - registered read data, holds between reads
//               Empty    - no entries stored
//               Full     - DEPTH entries stored
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_cg
  import fifo_cg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = c_data_width,
  parameter int unsigned ADDR_WIDTH = c_addr_width
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] Din,
  input  logic                  WR_EN,
  input  logic                  RD_EN,
  output logic [DATA_WIDTH-1:0] Dout,
  output logic                  Empty,
  output logic                  Full
);

  localparam int unsigned          c_depth    = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   c_full_cnt = (ADDR_WIDTH + 1)'(c_depth);
  localparam logic [ADDR_WIDTH:0]   c_cnt_one  = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] c_ptr_one  = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] r_wp;
  logic [ADDR_WIDTH-1:0] r_rp;
  logic [ADDR_WIDTH:0]   r_cnt;
  logic                  r_empty;
  logic                  r_full;

  logic                  w_wr_ok;
  logic                  w_rd_ok;
  logic [ADDR_WIDTH:0]   w_cnt_next;

  // Acceptance uses the registered flags, so on a full FIFO a simultaneous
  // read cannot make room for the write in the same cycle, and on an empty
  // FIFO there is no fall-through.
  assign w_wr_ok = WR_EN & ~r_full;
  assign w_rd_ok = RD_EN & ~r_empty;

  always_comb begin
    w_cnt_next = r_cnt;
    case ({w_wr_ok, w_rd_ok})
      2'b10:   w_cnt_next = r_cnt + c_cnt_one;
      2'b01:   w_cnt_next = r_cnt - c_cnt_one;
      default: w_cnt_next = r_cnt;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
    end else begin
      if (w_wr_ok) r_wp <= r_wp + c_ptr_one;
      if (w_rd_ok) r_rp <= r_rp + c_ptr_one;
      r_cnt   <= w_cnt_next;
      r_empty <= (w_cnt_next == '0);
      r_full  <= (w_cnt_next == c_full_cnt);
    end
  end

  fifo_cg_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (CLK),
    .rst     (RST),
    .i_we    (w_wr_ok),
    .i_waddr (r_wp),
    .i_wdata (Din),
    .i_re    (w_rd_ok),
    .i_raddr (r_rp),
    .o_rdata (Dout)
  );

  assign Empty = r_empty;
  assign Full  = r_full;

endmodule : fifo_cg
`default_nettype wire

// File: tb/tb_fifo_cg.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_cg
// Description : Directed self-checking bench for fifo_cg: reset, fill/drain,
//               overflow, underflow, simultaneous access, pointer wrap and
//               mid-operation reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_cg;
  import fifo_cg_pkg::*;

  logic  CLK;
  logic  RST;
  data_t Din;
  logic  WR_EN;
  logic  RD_EN;
  data_t Dout;
  logic  Empty;
  logic  Full;

  int n_cmp;
  int n_err;

  fifo_cg u_dut (
    .CLK   (CLK),
    .RST   (RST),
    .Din   (Din),
    .WR_EN (WR_EN),
    .RD_EN (RD_EN),
    .Dout  (Dout),
    .Empty (Empty),
    .Full  (Full)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One rising edge; inputs change and outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input data_t d);
    WR_EN = 1'b1; RD_EN = 1'b0; Din = d;
    step();
    WR_EN = 1'b0;
  endtask

  task automatic pop();
    WR_EN = 1'b0; RD_EN = 1'b1;
    step();
    RD_EN = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    RST = 1'b1; WR_EN = 1'b1; RD_EN = 1'b1; Din = 8'h77;

    // Reset dominates active requests.
    step();
    step();
    check("rst_empty", 32'(Empty), 32'd1);
    check("rst_full",  32'(Full),  32'd0);
    check("rst_dout",  32'(Dout),  32'h00);
    RST = 1'b0; WR_EN = 1'b0; RD_EN = 1'b0;
    step();
    check("rst_hold_empty", 32'(Empty), 32'd1);

    // Fill 0x00..0xFF.
    for (int i = 0; i < 256; i++) begin
      push(data_t'(i));
      check("fill_empty", 32'(Empty), 32'd0);
      check("fill_full",  32'(Full),  (i == 255) ? 32'd1 : 32'd0);
    end

    // Overflow write is dropped.
    push(8'hAB);
    check("ovf_full", 32'(Full), 32'd1);

    // Drain: 0x00..0xFF in order, 0xAB never appears.
    for (int i = 0; i < 256; i++) begin
      pop();
      check("drain_dout",  32'(Dout),  32'(i));
      check("drain_full",  32'(Full),  32'd0);
      check("drain_empty", 32'(Empty), (i == 255) ? 32'd1 : 32'd0);
    end
    pop();
    check("ovf_no_ab", 32'(Dout), 32'hFF);

    // Underflow after a read of 0x5A.
    push(8'h5A);
    pop();
    check("udf_first", 32'(Dout), 32'h5A);
    pop();
    check("udf_dout",  32'(Dout),  32'h5A);
    check("udf_empty", 32'(Empty), 32'd1);
    push(8'h11);
    pop();
    check("udf_recover", 32'(Dout), 32'h11);

    // Simultaneous read/write with 3 entries stored.
    push(8'h21);
    push(8'h22);
    push(8'h23);
    for (int i = 0; i < 4; i++) begin
      WR_EN = 1'b1; RD_EN = 1'b1; Din = data_t'(8'h24 + i);
      step();
      check("sim_dout",  32'(Dout),  32'(8'h21 + i));
      check("sim_empty", 32'(Empty), 32'd0);
      check("sim_full",  32'(Full),  32'd0);
    end
    WR_EN = 1'b0; RD_EN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pop();
      check("sim_tail", 32'(Dout), 32'(8'h25 + i));
    end
    check("sim_drained", 32'(Empty), 32'd1);

    // Both requests on an empty FIFO: write only, no fall-through.
    WR_EN = 1'b1; RD_EN = 1'b1; Din = 8'h31;
    step();
    WR_EN = 1'b0; RD_EN = 1'b0;
    check("emp_both_dout",  32'(Dout),  32'h27);
    check("emp_both_empty", 32'(Empty), 32'd0);
    pop();
    check("emp_both_read", 32'(Dout),  32'h31);
    check("emp_both_end",  32'(Empty), 32'd1);

    // Pointer wrap-around.
    for (int i = 0; i < 200; i++) push(data_t'(i * 3));
    for (int i = 0; i < 200; i++) begin
      pop();
      check("wrap_a", 32'(Dout), 32'(8'((i * 3) & 8'hFF)));
    end
    for (int i = 0; i < 100; i++) push(data_t'(i + 7));
    for (int i = 0; i < 50; i++) begin
      pop();
      check("wrap_b", 32'(Dout), 32'(i + 7));
    end
    check("wrap_b_empty", 32'(Empty), 32'd0);

    // Mid-operation reset with 50 entries stored.
    RST = 1'b1; WR_EN = 1'b1; RD_EN = 1'b1; Din = 8'hEE;
    step();
    RST = 1'b0; WR_EN = 1'b0; RD_EN = 1'b0;
    check("mrst_empty", 32'(Empty), 32'd1);
    check("mrst_full",  32'(Full),  32'd0);
    check("mrst_dout",  32'(Dout),  32'h00);
    push(8'h99);
    pop();
    check("mrst_after", 32'(Dout),  32'h99);
    check("mrst_end",   32'(Empty), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_fifo_cg
`default_nettype wire
